mips_datapath: RTL and testbench

Single-cycle MIPS-style execution datapath: 32×32 register file, sign-extender, ALU and a 64-word data memory, all steered by externally supplied control signals. It sits under the main control unit, which decodes `INST` and drives the control inputs. It exposes the write-back value, the ALU zero flag and the ALU result/memory address for the PC/branch logic and for debug.

---
 rtl/mips_datapath.sv | 120 ++++++++++++
 tb/tb_mips_datapath.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_datapath.sv
// Single-cycle MIPS-style execution datapath: 32x32 register file, sign extender, ALU, 64-word data memory.
// Optional feature: define DATAPATH_SLT_EN to enable signed set-less-than on ALUcontrol 4'b0111.
module mips_datapath (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] INST,
    input  logic        regDst,
    input  logic        regWrite,
    input  logic        ALUSrc,
    input  logic [3:0]  ALUcontrol,
    input  logic        memWrite,
    input  logic        memRead,
    input  logic        memtoReg,
    output logic [31:0] regW,
    output logic        isZero,
    output logic [31:0] addr
);

    localparam int DATA_W  = 32;
    localparam int NREGS   = 32;
    localparam int MWORDS  = 64;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    logic [DATA_W-1:0] rf_q  [NREGS];
    logic [DATA_W-1:0] rf_d  [NREGS];
    logic [DATA_W-1:0] mem_q [MWORDS];
    logic [DATA_W-1:0] mem_d [MWORDS];

    logic [4:0]               rs;
    logic [4:0]               rt;
    logic [4:0]               rd;
    logic [4:0]               dest;
    logic [5:0]               mem_idx;
    logic signed [DATA_W-1:0] imm_ext;
    logic signed [DATA_W-1:0] op_a;
    logic signed [DATA_W-1:0] op_b;
    logic [DATA_W-1:0]        rt_data;
    logic [DATA_W-1:0]        alu_res;
    logic [DATA_W-1:0]        mem_rdata;
    logic                     unused_inst;

    function automatic logic [DATA_W-1:0] alu_op(
        input logic [3:0]               op,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic [DATA_W-1:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
`ifdef DATAPATH_SLT_EN
            OP_SLT:  r = (a < b) ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
`else
            OP_SLT:  r = '0;
`endif
            OP_NOR:  r = ~(a | b);
            default: r = '0;
        endcase
        return r;
    endfunction

    assign rs          = INST[25:21];
    assign rt          = INST[20:16];
    assign rd          = INST[15:11];
    assign unused_inst = &{1'b0, INST[31:26]};

    // Operand fetch and execute; R0 is hard-wired to zero on both read ports.
    always_comb begin
        imm_ext   = {{16{INST[15]}}, INST[15:0]};
        op_a      = (rs == 5'd0) ? '0 : rf_q[rs];
        rt_data   = (rt == 5'd0) ? '0 : rf_q[rt];
        op_b      = ALUSrc ? imm_ext : rt_data;
        alu_res   = alu_op(ALUcontrol, op_a, op_b);
        mem_idx   = alu_res[7:2];
        mem_rdata = memRead ? mem_q[mem_idx] : '0;
        dest      = regDst ? rd : rt;
    end

    assign addr   = alu_res;
    assign isZero = (alu_res == '0);
    assign regW   = memtoReg ? mem_rdata : alu_res;

    always_comb begin
        rf_d = rf_q;
        if (regWrite && (dest != 5'd0)) begin
            rf_d[dest] = regW;
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (memWrite) begin
            mem_d[mem_idx] = rt_data;
        end
    end

    // State update; reset clears everything immediately and blocks writes while held.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
            for (int j = 0; j < MWORDS; j++) begin
                mem_q[j] <= '0;
            end
        end else begin
            rf_q  <= rf_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: tb/tb_mips_datapath.sv
// Scoreboard bench for mips_datapath: directed vectors push expectations, a negedge monitor checks them.
module tb_mips_datapath;

    localparam logic [3:0] A_AND = 4'b0000;
    localparam logic [3:0] A_OR  = 4'b0001;
    localparam logic [3:0] A_ADD = 4'b0010;
    localparam logic [3:0] A_SUB = 4'b0110;
    localparam logic [3:0] A_SLT = 4'b0111;
    localparam logic [3:0] A_NOR = 4'b1100;
    localparam logic [3:0] A_BAD = 4'b0011;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] INST = '0;
    logic        regDst = 1'b0;
    logic        regWrite = 1'b0;
    logic        ALUSrc = 1'b0;
    logic [3:0]  ALUcontrol = '0;
    logic        memWrite = 1'b0;
    logic        memRead = 1'b0;
    logic        memtoReg = 1'b0;
    logic [31:0] regW;
    logic        isZero;
    logic [31:0] addr;

    mips_datapath dut (
        .CLK        (CLK),
        .RST        (RST),
        .INST       (INST),
        .regDst     (regDst),
        .regWrite   (regWrite),
        .ALUSrc     (ALUSrc),
        .ALUcontrol (ALUcontrol),
        .memWrite   (memWrite),
        .memRead    (memRead),
        .memtoReg   (memtoReg),
        .regW       (regW),
        .isZero     (isZero),
        .addr       (addr)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [31:0] regw;
        logic        zero;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
    endfunction

    function automatic logic [31:0] itype(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {6'b001000, rs, rt, imm};
    endfunction

    task automatic push_exp(input string nm, input logic [31:0] e_regw, input logic [31:0] e_addr);
        exp_t e;
        e.name = nm;
        e.regw = e_regw;
        e.zero = (e_addr == 32'd0);
        e.addr = e_addr;
        sb.push_back(e);
    endtask

    task automatic step(input string nm, input logic [31:0] inst, input logic [3:0] alu,
                        input logic src, input logic dst, input logic rw, input logic mw,
                        input logic mr, input logic m2r,
                        input logic [31:0] e_regw, input logic [31:0] e_addr);
        @(posedge CLK);
        #1;
        INST = inst; ALUcontrol = alu; ALUSrc = src; regDst = dst;
        regWrite = rw; memWrite = mw; memRead = mr; memtoReg = m2r;
        push_exp(nm, e_regw, e_addr);
    endtask

    task automatic rd_reg(input string nm, input logic [4:0] r, input logic [31:0] v);
        step(nm, rtype(r, 5'd0, 5'd0), A_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, v, v);
    endtask

    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_assert++;
            if (regW !== e.regw) begin
                n_fail++;
                $display("FAIL %s regW: got %h expected %h", e.name, regW, e.regw);
            end
            n_assert++;
            if (isZero !== e.zero) begin
                n_fail++;
                $display("FAIL %s isZero: got %b expected %b", e.name, isZero, e.zero);
            end
            n_assert++;
            if (addr !== e.addr) begin
                n_fail++;
                $display("FAIL %s addr: got %h expected %h", e.name, addr, e.addr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d expected 0", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] dbl;
        logic [31:0] slt_exp;

        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        // Zeroed state: add into R17 gives 0.
        step("rst_add", 32'h02538820, A_ADD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        rd_reg("rst_r17", 5'd17, 32'd0);

        // Immediate path.
        step("addi_r18", 32'h20120005, A_ADD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd5, 32'd5);
        rd_reg("rd_r18", 5'd18, 32'd5);
        step("imm_neg", itype(5'd0, 5'd18, 16'hFFFF), A_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
             32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Register-register ops with R18=5, R19=7.
        step("addi_r19", itype(5'd0, 5'd19, 16'd7), A_ADD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd7, 32'd7);
        step("add_r17", 32'h02538820, A_ADD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd12, 32'd12);
        rd_reg("rd_r17", 5'd17, 32'd12);
        step("sub", 32'h02538820, A_SUB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFE);
        step("sub_self", rtype(5'd18, 5'd18, 5'd0), A_SUB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step("and", 32'h02538820, A_AND, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5, 32'd5);
        step("or", 32'h02538820, A_OR, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd7, 32'd7);
        step("nor", 32'h02538820, A_NOR, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'hFFFF_FFF8);
        step("bad_op", 32'h02538820, A_BAD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        // SLT: R21 = -1 compared with imm 1.
        step("addi_r21", itype(5'd0, 5'd21, 16'hFFFF), A_ADD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
             32'hFFFF_FFFF, 32'hFFFF_FFFF);
`ifdef DATAPATH_SLT_EN
        slt_exp = 32'd1;
`else
        slt_exp = 32'd0;
`endif
        step("slt_m1_1", itype(5'd21, 5'd0, 16'd1), A_SLT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, slt_exp, slt_exp);

        // Build R19 = 0xDEADBEEF: R23 = 0xFFFFDEAD shifted left 16 by doubling, R24 = 0x0000BEEF, OR them.
        step("addi_r23", itype(5'd0, 5'd23, 16'hDEAD), A_ADD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
             32'hFFFF_DEAD, 32'hFFFF_DEAD);
        dbl = 32'hFFFF_DEAD;
        for (int i = 0; i < 16; i++) begin
            dbl = dbl << 1;
            step("dbl_r23", rtype(5'd23, 5'd23, 5'd23), A_ADD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, dbl, dbl);
        end
        rd_reg("rd_r23", 5'd23, 32'hDEAD_0000);
        step("addi_r24", itype(5'd0, 5'd24, 16'h7EEF), A_ADD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
             32'h0000_7EEF, 32'h0000_7EEF);
        step("addi_r24b", itype(5'd24, 5'd24, 16'h4000), A_ADD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
             32'h0000_BEEF, 32'h0000_BEEF);
        step("or_r19", rtype(5'd23, 5'd24, 5'd19), A_OR, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
             32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // Store then load through memory word 2.
        step("store", itype(5'd0, 5'd19, 16'd8), A_ADD, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd8, 32'd8);
        step("load", itype(5'd0, 5'd20, 16'd8), A_ADD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
             32'hDEAD_BEEF, 32'd8);
        rd_reg("rd_r20", 5'd20, 32'hDEAD_BEEF);
        step("no_memrd", itype(5'd0, 5'd20, 16'd8), A_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd8);
        step("alias", itype(5'd0, 5'd20, 16'h010A), A_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
             32'hDEAD_BEEF, 32'h0000_010A);

        // Read-during-write on memory returns the old word; new word visible next cycle.
        step("mem_rdw", itype(5'd0, 5'd18, 16'd8), A_ADD, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
             32'hDEAD_BEEF, 32'd8);
        step("mem_new", itype(5'd0, 5'd18, 16'd8), A_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd5, 32'd8);

        // R0 is not writable.
        step("wr_r0", itype(5'd0, 5'd0, 16'd9), A_ADD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd9, 32'd9);
        rd_reg("rd_r0", 5'd0, 32'd0);

        // Async reset between edges with a write to R18 pending.
        @(posedge CLK);
        #1;
        INST = itype(5'd18, 5'd18, 16'd1); ALUcontrol = A_ADD; ALUSrc = 1'b1; regDst = 1'b0;
        regWrite = 1'b1; memWrite = 1'b0; memRead = 1'b0; memtoReg = 1'b0;
        #1 RST = 1'b1;
        push_exp("async_rst", 32'd1, 32'd1);
        @(posedge CLK);
        #1;
        regWrite = 1'b0;
        RST = 1'b0;
        rd_reg("rst_r18", 5'd18, 32'd0);
        step("rst_mem", itype(5'd0, 5'd20, 16'd8), A_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 32'd8);

        repeat (2) @(negedge CLK);
        n_assert++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: queue depth %0d expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
